// File: rtl/tw_load_pkg.sv
// Shared types and constants for the horizontal twiddle loader.
// Holds the ROM5_w write codes, the loader FSM state encoding and default widths.
package tw_load_pkg;

    localparam int DEF_P_WIDTH         = 128;
    localparam int DEF_HORIZONTAL_DW   = 64;
    localparam int DEF_INIT_STORE_DATA = 4;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_HI   = 2'd1;
    localparam logic [1:0] W_LO   = 2'd2;

    // GAP is only reachable when TW_LOAD_GAP_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        SEND_HI,
        SEND_LO,
        DONE,
        GAP
    } state_e;

endpackage

// File: rtl/tw_word_buf.sv
// Small register file holding the twiddle words of one load.
// Single write port plus a combinational read that returns the upper or lower half of a word.
module tw_word_buf
    import tw_load_pkg::*;
#(
    parameter int DEPTH         = DEF_INIT_STORE_DATA,
    parameter int P_WIDTH       = DEF_P_WIDTH,
    parameter int HORIZONTAL_DW = DEF_HORIZONTAL_DW,
    parameter int AW            = $clog2(DEF_INIT_STORE_DATA)
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [P_WIDTH-1:0]       wr_data_i,
    input  logic [AW-1:0]            rd_addr_i,
    input  logic                     rd_hi_i,
    output logic [HORIZONTAL_DW-1:0] rd_data_o
);

    logic [P_WIDTH-1:0] mem_q [DEPTH];

    // Contents need no reset: every entry is rewritten before it is read out.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_data_o = rd_hi_i ? mem_q[rd_addr_i][P_WIDTH-1:HORIZONTAL_DW]
                            : mem_q[rd_addr_i][HORIZONTAL_DW-1:0];
    end

endmodule

// File: rtl/tw_horizontal_loader.sv
// Collects four twiddle words, then streams all upper halves followed by all lower halves.
// Optional macro TW_LOAD_GAP_EN inserts one idle beat between the upper and lower half-bursts.
module tw_horizontal_loader
    import tw_load_pkg::*;
#(
    parameter int P_WIDTH         = DEF_P_WIDTH,
    parameter int HORIZONTAL_DW   = DEF_HORIZONTAL_DW,
    parameter int INIT_STORE_DATA = DEF_INIT_STORE_DATA,
    parameter int CNT_W           = $clog2(DEF_INIT_STORE_DATA)
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     tw_valid,
    input  logic [P_WIDTH-1:0]       tw_data,
    output logic                     tw_ready,
    output logic [HORIZONTAL_DW-1:0] horizontal_data_out,
    output logic [1:0]               ROM5_w,
    output logic                     busy,
    output logic                     done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(INIT_STORE_DATA - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         fill_q, fill_d;
    logic [CNT_W-1:0]         beat_q, beat_d;
    logic                     tw_ready_q, tw_ready_d;
    logic [1:0]               rom5_w_q, rom5_w_d;
    logic [HORIZONTAL_DW-1:0] data_q, data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     wr_en;
    logic                     rd_hi;
    logic [HORIZONTAL_DW-1:0] rd_data;

    tw_word_buf #(
        .DEPTH         (INIT_STORE_DATA),
        .P_WIDTH       (P_WIDTH),
        .HORIZONTAL_DW (HORIZONTAL_DW),
        .AW            (CNT_W)
    ) u_buf (
        .clk_i     (CLK),
        .wr_en_i   (wr_en),
        .wr_addr_i (fill_q),
        .wr_data_i (tw_data),
        .rd_addr_i (beat_d),
        .rd_hi_i   (rd_hi),
        .rd_data_o (rd_data)
    );

    // Outputs are computed from the next state so they can be registered without adding latency.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        beat_d  = beat_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            end
            FILL: begin
                if (tw_valid && tw_ready_q) begin
                    wr_en  = 1'b1;
                    fill_d = fill_q + 1'b1;
                    if (fill_q == LAST) begin
                        state_d = SEND_HI;
                        beat_d  = '0;
                    end
                end
            end
            SEND_HI: begin
                if (beat_q == LAST) begin
`ifdef TW_LOAD_GAP_EN
                    state_d = GAP;
`else
                    state_d = SEND_LO;
`endif
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            GAP: begin
                state_d = SEND_LO;
                beat_d  = '0;
            end
            SEND_LO: begin
                if (beat_q == LAST) begin
                    state_d = DONE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_hi      = (state_d == SEND_HI);
        rom5_w_d   = (state_d == SEND_HI) ? W_HI :
                     (state_d == SEND_LO) ? W_LO : W_IDLE;
        data_d     = (rom5_w_d != W_IDLE) ? rd_data : '0;
        tw_ready_d = (state_d == FILL);
        busy_d     = (state_d == FILL) || (state_d == SEND_HI) ||
                     (state_d == SEND_LO) || (state_d == GAP);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fill_q     <= '0;
            beat_q     <= '0;
            tw_ready_q <= 1'b0;
            rom5_w_q   <= W_IDLE;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            beat_q     <= beat_d;
            tw_ready_q <= tw_ready_d;
            rom5_w_q   <= rom5_w_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tw_ready            = tw_ready_q;
    assign horizontal_data_out = data_q;
    assign ROM5_w              = rom5_w_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_tw_horizontal_loader.sv
// Self-checking bench for tw_horizontal_loader: table vectors, random loads against a
// stream/receiver reference model, ignored starts, back-to-back loads and reset mid-burst.
module tb_tw_horizontal_loader;

    logic         CLK = 1'b0;
    logic         rst_n;
    logic         start;
    logic         tw_valid;
    logic [127:0] tw_data;
    logic         tw_ready;
    logic [63:0]  horizontal_data_out;
    logic [1:0]   ROM5_w;
    logic         busy;
    logic         done;

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic [3:0][127:0] w;
        logic [3:0][63:0]  expHi;
        logic [3:0][63:0]  expLo;
        int                stallPos;
        int                stallLen;
        bit                extraStarts;
    } vec_t;

    vec_t         tbl [3];
    logic [127:0] rxBuf [4];
    logic [1:0]   rxCnt;
    int           hiRun;
    int           loRun;

    tw_horizontal_loader dut (
        .CLK                 (CLK),
        .rst_n               (rst_n),
        .start               (start),
        .tw_valid            (tw_valid),
        .tw_data             (tw_data),
        .tw_ready            (tw_ready),
        .horizontal_data_out (horizontal_data_out),
        .ROM5_w              (ROM5_w),
        .busy                (busy),
        .done                (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Paired receiver: entry counter advances per written beat and restarts whenever ROM5_w is idle.
    always @(negedge CLK) begin
        if (!rst_n) begin
            hiRun = 0;
            loRun = 0;
            rxCnt = 2'd0;
        end else begin
            check("rom5wNever3", {127'd0, ROM5_w == 2'd3}, 128'd0);
            if (ROM5_w == 2'd0) begin
                check("dataZeroWhenIdle", {64'd0, horizontal_data_out}, 128'd0);
                rxCnt = 2'd0;
            end else if (ROM5_w == 2'd1) begin
                rxBuf[rxCnt][127:64] = horizontal_data_out;
                rxCnt = rxCnt + 2'd1;
            end else if (ROM5_w == 2'd2) begin
                rxBuf[rxCnt][63:0] = horizontal_data_out;
                rxCnt = rxCnt + 2'd1;
            end
            if (ROM5_w == 2'd1) begin
                hiRun++;
            end else if (hiRun != 0) begin
                check("hiRunLength", 128'(hiRun), 128'd4);
                hiRun = 0;
            end
            if (ROM5_w == 2'd2) begin
                loRun++;
            end else if (loRun != 0) begin
                check("loRunLength", 128'(loRun), 128'd4);
                loRun = 0;
            end
        end
    end

    // Pulses start in IDLE (with junk on tw_valid), then feeds four words with an optional stall.
    task automatic applyStimulus(input logic [3:0][127:0] w, input int stallPos, input int stallLen);
        int idx     = 0;
        int stalled = 0;
        int budget  = 0;
        bit hs;
        check("idleBusy", {127'd0, busy}, 128'd0);
        check("idleReady", {127'd0, tw_ready}, 128'd0);
        check("idleRom5w", {126'd0, ROM5_w}, 128'd0);
        start    = 1'b1;
        tw_valid = 1'b1;
        tw_data  = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        tick();
        start = 1'b0;
        check("busyAfterStart", {127'd0, busy}, 128'd1);
        while (idx < 4 && budget < 200) begin
            check($sformatf("fillReady[%0d]", idx), {127'd0, tw_ready}, 128'd1);
            if (idx == stallPos && stalled < stallLen) begin
                tw_valid = 1'b0;
                stalled++;
            end else begin
                tw_valid = 1'b1;
                tw_data  = w[idx];
            end
            hs = tw_valid && tw_ready;
            tick();
            if (hs) idx++;
            budget++;
        end
        tw_valid = 1'b0;
        tw_data  = '0;
        if (idx < 4) check("fillTimeout", 128'(idx), 128'd4);
    endtask

    // Starts in the cycle after the fourth handshake; checks every beat, done, and the receiver buffer.
    task automatic checkOutput(input logic [3:0][127:0] w, input logic [3:0][63:0] expHi,
                               input logic [3:0][63:0] expLo, input bit extraStarts);
        logic [1:0]  qCode [$];
        logic [63:0] qData [$];
        for (int k = 0; k < 4; k++) begin
            qCode.push_back(2'd1);
            qData.push_back(expHi[k]);
        end
`ifdef TW_LOAD_GAP_EN
        qCode.push_back(2'd0);
        qData.push_back(64'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            qCode.push_back(2'd2);
            qData.push_back(expLo[k]);
        end
        check("readyDropped", {127'd0, tw_ready}, 128'd0);
        for (int i = 0; i < qCode.size(); i++) begin
            check($sformatf("beatCode[%0d]", i), {126'd0, ROM5_w}, {126'd0, qCode[i]});
            check($sformatf("beatData[%0d]", i), {64'd0, horizontal_data_out}, {64'd0, qData[i]});
            check($sformatf("beatBusy[%0d]", i), {127'd0, busy}, 128'd1);
            check($sformatf("beatDone[%0d]", i), {127'd0, done}, 128'd0);
            if (extraStarts && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("doneHigh", {127'd0, done}, 128'd1);
        check("doneRom5w", {126'd0, ROM5_w}, 128'd0);
        check("doneData", {64'd0, horizontal_data_out}, 128'd0);
        check("doneBusy", {127'd0, busy}, 128'd0);
        if (extraStarts) start = 1'b1;
        tick();
        start = 1'b0;
        check("doneOnePulse", {127'd0, done}, 128'd0);
        check("backToIdleBusy", {127'd0, busy}, 128'd0);
        check("backToIdleReady", {127'd0, tw_ready}, 128'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rxWord[%0d]", k), rxBuf[k], w[k]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][127:0] rw;
        logic [3:0][63:0]  rHi;
        logic [3:0][63:0]  rLo;
        logic [127:0]      shifted;

        rst_n    = 1'b0;
        start    = 1'b0;
        tw_valid = 1'b0;
        tw_data  = '0;

        tbl[0].w     = {128'h00000040003fffc0_fbc8a1ec30654b2b, 128'h7fffffff00000001_fffffffdffff0002,
                        128'h007fffffffffff80_3babf8a70b9016d7, 128'h0000000000000001_0000000000000001};
        tbl[0].expHi = {64'h00000040003fffc0, 64'h7fffffff00000001, 64'h007fffffffffff80, 64'h0000000000000001};
        tbl[0].expLo = {64'hfbc8a1ec30654b2b, 64'hfffffffdffff0002, 64'h3babf8a70b9016d7, 64'h0000000000000001};
        tbl[0].stallPos = 9;  tbl[0].stallLen = 0;  tbl[0].extraStarts = 1'b0;
        tbl[1] = tbl[0];
        tbl[1].stallPos = 1;  tbl[1].stallLen = 3;
        tbl[2].w     = {128'h8000000000000001_7ffffffffffffffe, 128'h0000000000000000_ffffffffffffffff,
                        128'hffffffffffffffff_0000000000000000, 128'h0123456789abcdef_fedcba9876543210};
        tbl[2].expHi = {64'h8000000000000001, 64'h0000000000000000, 64'hffffffffffffffff, 64'h0123456789abcdef};
        tbl[2].expLo = {64'h7ffffffffffffffe, 64'hffffffffffffffff, 64'h0000000000000000, 64'hfedcba9876543210};
        tbl[2].stallPos = 9;  tbl[2].stallLen = 0;  tbl[2].extraStarts = 1'b1;

        repeat (2) @(posedge CLK);
        #1;
        check("rstReady", {127'd0, tw_ready}, 128'd0);
        check("rstRom5w", {126'd0, ROM5_w}, 128'd0);
        check("rstData", {64'd0, horizontal_data_out}, 128'd0);
        check("rstBusy", {127'd0, busy}, 128'd0);
        check("rstDone", {127'd0, done}, 128'd0);
        rst_n = 1'b1;
        tick();

        // Table vectors run back to back: each load starts in the first IDLE cycle after done.
        for (int v = 0; v < 3; v++) begin
            applyStimulus(tbl[v].w, tbl[v].stallPos, tbl[v].stallLen);
            checkOutput(tbl[v].w, tbl[v].expHi, tbl[v].expLo, tbl[v].extraStarts);
        end

        // Random loads: expected halves come straight from the word value by shifting.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                rw[k]   = {$urandom, $urandom, $urandom, $urandom};
                shifted = rw[k] >> 64;
                rHi[k]  = shifted[63:0];
                rLo[k]  = rw[k][63:0];
            end
            applyStimulus(rw, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            checkOutput(rw, rHi, rLo, r[0]);
            if (r == 2) repeat (3) tick();
        end

        // Reset asserted during the second lower-half beat.
        applyStimulus(tbl[0].w, 9, 0);
        repeat (5) tick();
`ifdef TW_LOAD_GAP_EN
        tick();
`endif
        check("preResetLoBeat", {126'd0, ROM5_w}, 128'd2);
        check("preResetLoData", {64'd0, horizontal_data_out}, {64'd0, tbl[0].expLo[1]});
        rst_n = 1'b0;
        #1;
        check("asyncRstRom5w", {126'd0, ROM5_w}, 128'd0);
        check("asyncRstData", {64'd0, horizontal_data_out}, 128'd0);
        check("asyncRstBusy", {127'd0, busy}, 128'd0);
        check("asyncRstDone", {127'd0, done}, 128'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(tbl[2].w, 2, 2);
        checkOutput(tbl[2].w, tbl[2].expHi, tbl[2].expLo, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
